// File: rtl/multi_ch_serial_dispatch.sv
// multi_ch_serial_dispatch: routes decoded command packets to CH_NUM serial_out
// channels, tracking per-channel busy state and one pending command per channel.
// Optional feature macro: BROADCAST_EN (sel = all ones targets every channel).
module multi_ch_serial_dispatch #(
  parameter int unsigned DATA_BIT = 32,
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned SEL_BIT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_pkt_valid,
  output logic                         o_pkt_ready,
  input  logic [DATA_BIT-1:0]          i_output_pattern,
  input  logic [DATA_BIT-1:0]          i_freq_pattern,
  input  logic [SEL_BIT-1:0]           i_sel_out,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_mode,
  input  logic [CH_NUM-1:0]            i_ch_done_tick,
  output logic [CH_NUM-1:0]            o_ch_start,
  output logic [CH_NUM-1:0]            o_ch_stop,
  output logic [CH_NUM-1:0]            o_ch_mode,
  output logic [CH_NUM*DATA_BIT-1:0]   o_ch_output_pattern,
  output logic [CH_NUM*DATA_BIT-1:0]   o_ch_freq_pattern,
  output logic [CH_NUM-1:0]            o_ch_busy,
  output logic                         o_update_done_tick,
  output logic                         o_overwrite_tick,
  output logic                         o_err_tick
);

  localparam int unsigned PW = CH_NUM * DATA_BIT;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;

  logic [1:0]          r_state, w_state_nxt;
  logic                r_pkt_ready;
  logic [DATA_BIT-1:0] r_pkt_pat, r_pkt_freq;
  logic [SEL_BIT-1:0]  r_sel;
  logic                r_start, r_stop, r_mode;

  logic [CH_NUM-1:0]   r_busy, r_pend_v, r_pend_mode, r_ch_mode, r_ch_start, r_ch_stop;
  logic [DATA_BIT-1:0] r_pend_pat  [CH_NUM];
  logic [DATA_BIT-1:0] r_pend_freq [CH_NUM];
  logic [PW-1:0]       r_ch_pat, r_ch_freq;
  logic                r_upd_tick, r_ovw_tick, r_err_tick;

  logic                w_dispatch, w_sel_in_range, w_bcast, w_range_err;
  logic [CH_NUM-1:0]   w_hit, w_done_eff, w_issue_pend, w_free, w_do_stop;
  logic [CH_NUM-1:0]   w_new_start, w_to_pend, w_load_only, w_busy_err, w_ovw;

  // Central FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Central FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (i_pkt_valid) w_state_nxt = S_DISPATCH;
      S_DISPATCH: w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Packet capture in idle and FSM-level registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_pat   <= '0;
      r_pkt_freq  <= '0;
      r_sel       <= '0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_mode      <= 1'b0;
      r_pkt_ready <= 1'b1;
      r_upd_tick  <= 1'b0;
      r_ovw_tick  <= 1'b0;
      r_err_tick  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_pkt_valid) begin
        r_pkt_pat  <= i_output_pattern;
        r_pkt_freq <= i_freq_pattern;
        r_sel      <= i_sel_out;
        r_start    <= i_start;
        r_stop     <= i_stop;
        r_mode     <= i_mode;
      end
      r_pkt_ready <= (w_state_nxt == S_IDLE);
      r_upd_tick  <= w_dispatch;
      r_ovw_tick  <= |w_ovw;
      r_err_tick  <= w_range_err | (|w_busy_err);
    end
  end

  // Per-channel routing decisions; a done tick with no pending command frees the channel
  always_comb begin
    w_dispatch     = (r_state == S_DISPATCH);
    w_sel_in_range = ({1'b0, r_sel} < (SEL_BIT+1)'(CH_NUM));
`ifdef BROADCAST_EN
    w_bcast        = (r_sel == {SEL_BIT{1'b1}});
`else
    w_bcast        = 1'b0;
`endif
    w_range_err    = w_dispatch & ~w_sel_in_range & ~w_bcast;
    w_hit          = '0;
    w_done_eff     = '0;
    w_issue_pend   = '0;
    w_free         = '0;
    w_do_stop      = '0;
    w_new_start    = '0;
    w_to_pend      = '0;
    w_load_only    = '0;
    w_busy_err     = '0;
    w_ovw          = '0;
    for (int k = 0; k < int'(CH_NUM); k++) begin
      w_hit[k]        = w_dispatch & ((w_sel_in_range & (r_sel == SEL_BIT'(k))) | w_bcast);
      w_do_stop[k]    = w_hit[k] & r_stop;
      w_done_eff[k]   = i_ch_done_tick[k] & r_busy[k];
      w_issue_pend[k] = w_done_eff[k] & r_pend_v[k] & ~w_do_stop[k];
      w_free[k]       = ~r_busy[k] | (w_done_eff[k] & ~r_pend_v[k]);
      w_new_start[k]  = w_hit[k] & ~r_stop & r_start & w_free[k];
      w_to_pend[k]    = w_hit[k] & ~r_stop & r_start & ~w_free[k];
      w_load_only[k]  = w_hit[k] & ~r_stop & ~r_start & w_free[k];
      w_busy_err[k]   = w_hit[k] & ~r_stop & ~r_start & ~w_free[k];
      w_ovw[k]        = w_to_pend[k] & r_pend_v[k] & ~w_issue_pend[k];
    end
  end

  // Per-channel busy, pending slot and held output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_pend_v    <= '0;
      r_pend_mode <= '0;
      r_ch_mode   <= '0;
      r_ch_start  <= '0;
      r_ch_stop   <= '0;
      r_ch_pat    <= '0;
      r_ch_freq   <= '0;
      for (int k = 0; k < int'(CH_NUM); k++) begin
        r_pend_pat[k]  <= '0;
        r_pend_freq[k] <= '0;
      end
    end else begin
      r_ch_start <= w_new_start | w_issue_pend;
      r_ch_stop  <= w_do_stop;
      for (int k = 0; k < int'(CH_NUM); k++) begin
        if (w_do_stop[k]) begin
          r_busy[k]   <= 1'b0;
          r_pend_v[k] <= 1'b0;
        end else begin
          if (w_issue_pend[k]) begin
            r_ch_pat[k*DATA_BIT +: DATA_BIT]  <= r_pend_pat[k];
            r_ch_freq[k*DATA_BIT +: DATA_BIT] <= r_pend_freq[k];
            r_ch_mode[k]                      <= r_pend_mode[k];
            r_pend_v[k]                       <= 1'b0;
          end else if (w_done_eff[k]) begin
            r_busy[k] <= 1'b0;
          end
          if (w_new_start[k] || w_load_only[k]) begin
            r_ch_pat[k*DATA_BIT +: DATA_BIT]  <= r_pkt_pat;
            r_ch_freq[k*DATA_BIT +: DATA_BIT] <= r_pkt_freq;
            r_ch_mode[k]                      <= r_mode;
          end
          if (w_new_start[k]) r_busy[k] <= 1'b1;
          if (w_to_pend[k]) begin
            r_pend_pat[k]  <= r_pkt_pat;
            r_pend_freq[k] <= r_pkt_freq;
            r_pend_mode[k] <= r_mode;
            r_pend_v[k]    <= 1'b1;
          end
        end
      end
    end
  end

  assign o_pkt_ready         = r_pkt_ready;
  assign o_ch_start          = r_ch_start;
  assign o_ch_stop           = r_ch_stop;
  assign o_ch_mode           = r_ch_mode;
  assign o_ch_output_pattern = r_ch_pat;
  assign o_ch_freq_pattern   = r_ch_freq;
  assign o_ch_busy           = r_busy;
  assign o_update_done_tick  = r_upd_tick;
  assign o_overwrite_tick    = r_ovw_tick;
  assign o_err_tick          = r_err_tick;

endmodule

// File: tb/tb_multi_ch_serial_dispatch.sv
// Testbench for multi_ch_serial_dispatch: directed scenarios followed by random
// traffic, all checked every cycle against a channel-level behavioural model.
module tb_multi_ch_serial_dispatch;

  localparam int DW = 32;
  localparam int CN = 4;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_pkt_valid;
  logic            o_pkt_ready;
  logic [DW-1:0]   i_output_pattern, i_freq_pattern;
  logic [SW-1:0]   i_sel_out;
  logic            i_start, i_stop, i_mode;
  logic [CN-1:0]   i_ch_done_tick;
  logic [CN-1:0]   o_ch_start, o_ch_stop, o_ch_mode, o_ch_busy;
  logic [CN*DW-1:0] o_ch_output_pattern, o_ch_freq_pattern;
  logic            o_update_done_tick, o_overwrite_tick, o_err_tick;

  multi_ch_serial_dispatch #(.DATA_BIT(DW), .CH_NUM(CN), .SEL_BIT(SW)) dut (
    .clk(clk), .rst(rst), .i_pkt_valid(i_pkt_valid), .o_pkt_ready(o_pkt_ready),
    .i_output_pattern(i_output_pattern), .i_freq_pattern(i_freq_pattern),
    .i_sel_out(i_sel_out), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
    .i_ch_done_tick(i_ch_done_tick), .o_ch_start(o_ch_start), .o_ch_stop(o_ch_stop),
    .o_ch_mode(o_ch_mode), .o_ch_output_pattern(o_ch_output_pattern),
    .o_ch_freq_pattern(o_ch_freq_pattern), .o_ch_busy(o_ch_busy),
    .o_update_done_tick(o_update_done_tick), .o_overwrite_tick(o_overwrite_tick),
    .o_err_tick(o_err_tick)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: per-channel records plus packet phase counter
  int        m_phase;
  int        p_sel;
  bit        p_start, p_stop, p_mode;
  logic [DW-1:0] p_pat, p_freq;
  bit        m_busy [CN];
  bit        m_pv   [CN];
  logic [DW-1:0] m_out_pat [CN], m_out_freq [CN], m_pend_pat [CN], m_pend_freq [CN];
  bit        m_out_mode [CN], m_pend_mode [CN];
  logic [CN-1:0] e_start, e_stop;
  bit        e_ready, e_upd, e_ovw, e_err;

  task automatic check(input string tag, input logic [CN*DW-1:0] obs, input logic [CN*DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; e_ready = 1; e_upd = 0; e_ovw = 0; e_err = 0;
    e_start = '0; e_stop = '0;
    for (int k = 0; k < CN; k++) begin
      m_busy[k] = 0; m_pv[k] = 0; m_out_mode[k] = 0; m_pend_mode[k] = 0;
      m_out_pat[k] = '0; m_out_freq[k] = '0; m_pend_pat[k] = '0; m_pend_freq[k] = '0;
    end
  endtask

  // One clock of the model, using the inputs presented during that cycle
  task automatic model_step();
    bit bcast, target, done, free;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef BROADCAST_EN
    bcast = 1;
`else
    bcast = 0;
`endif
    e_start = '0; e_stop = '0; e_ovw = 0; e_err = 0;
    e_upd = (m_phase == 1);
    if (m_phase == 1 && p_sel >= CN && !(bcast && p_sel == 15)) e_err = 1;
    for (int k = 0; k < CN; k++) begin
      target = (m_phase == 1) && (p_sel == k || (bcast && p_sel == 15));
      done   = i_ch_done_tick[k] && m_busy[k];
      if (target && p_stop) begin
        e_stop[k] = 1; m_busy[k] = 0; m_pv[k] = 0;
        continue;
      end
      free = !m_busy[k] || (done && !m_pv[k]);
      if (done && m_pv[k]) begin
        m_out_pat[k] = m_pend_pat[k]; m_out_freq[k] = m_pend_freq[k];
        m_out_mode[k] = m_pend_mode[k]; e_start[k] = 1; m_pv[k] = 0;
      end else if (done) begin
        m_busy[k] = 0;
      end
      if (target && p_start) begin
        if (free) begin
          m_out_pat[k] = p_pat; m_out_freq[k] = p_freq; m_out_mode[k] = p_mode;
          e_start[k] = 1; m_busy[k] = 1;
        end else begin
          if (m_pv[k]) e_ovw = 1;
          m_pend_pat[k] = p_pat; m_pend_freq[k] = p_freq; m_pend_mode[k] = p_mode;
          m_pv[k] = 1;
        end
      end else if (target) begin
        if (free) begin
          m_out_pat[k] = p_pat; m_out_freq[k] = p_freq; m_out_mode[k] = p_mode;
        end else begin
          e_err = 1;
        end
      end
    end
    if (m_phase == 0) begin
      if (i_pkt_valid) begin
        m_phase = 1;
        p_sel = int'(i_sel_out); p_start = i_start; p_stop = i_stop; p_mode = i_mode;
        p_pat = i_output_pattern; p_freq = i_freq_pattern;
      end
    end else if (m_phase == 1) m_phase = 2;
    else m_phase = 0;
    e_ready = (m_phase == 0);
  endtask

  task automatic compare_all();
    logic [CN*DW-1:0] ep, ef;
    logic [CN-1:0] eb, em;
    for (int k = 0; k < CN; k++) begin
      ep[k*DW +: DW] = m_out_pat[k];
      ef[k*DW +: DW] = m_out_freq[k];
      eb[k] = m_busy[k];
      em[k] = m_out_mode[k];
    end
    check("ready",   (CN*DW)'(o_pkt_ready), (CN*DW)'(e_ready));
    check("start",   (CN*DW)'(o_ch_start), (CN*DW)'(e_start));
    check("stop",    (CN*DW)'(o_ch_stop), (CN*DW)'(e_stop));
    check("mode",    (CN*DW)'(o_ch_mode), (CN*DW)'(em));
    check("busy",    (CN*DW)'(o_ch_busy), (CN*DW)'(eb));
    check("pattern", o_ch_output_pattern, ep);
    check("freq",    o_ch_freq_pattern, ef);
    check("upd",     (CN*DW)'(o_update_done_tick), (CN*DW)'(e_upd));
    check("ovw",     (CN*DW)'(o_overwrite_tick), (CN*DW)'(e_ovw));
    check("err",     (CN*DW)'(o_err_tick), (CN*DW)'(e_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Presents a packet; returns during the cycle its effects are visible
  task automatic send_pkt(input int sel, input bit st, input bit sp, input bit md,
                          input logic [DW-1:0] pat, input logic [CN-1:0] done_disp);
    i_pkt_valid = 1; i_sel_out = SW'(sel); i_start = st; i_stop = sp; i_mode = md;
    i_output_pattern = pat; i_freq_pattern = ~pat;
    tick();
    i_pkt_valid = 0; i_ch_done_tick = done_disp;
    tick();
    i_ch_done_tick = '0;
  endtask

  initial begin
    rst = 1; i_pkt_valid = 0; i_output_pattern = '0; i_freq_pattern = '0;
    i_sel_out = '0; i_start = 0; i_stop = 0; i_mode = 0; i_ch_done_tick = '0;
    model_reset();
    @(negedge clk);
    tick();
    rst = 0;
    check("reset_busy", (CN*DW)'(o_ch_busy), '0);
    check("reset_ready", (CN*DW)'(o_pkt_ready), (CN*DW)'(1));
    tick();

    // Basic start on idle channel 0
    send_pkt(0, 1, 0, 0, 32'hA5A5_0001, '0);
    check("t1_start", (CN*DW)'(o_ch_start), (CN*DW)'(4'b0001));
    check("t1_slice0", (CN*DW)'(o_ch_output_pattern[0 +: DW]), (CN*DW)'(32'hA5A5_0001));
    check("t1_busy0", (CN*DW)'(o_ch_busy[0]), (CN*DW)'(1));
    check("t1_upd", (CN*DW)'(o_update_done_tick), (CN*DW)'(1));
    tick();

    // Pending command issued on done tick
    send_pkt(1, 1, 0, 1, 32'h0000_CAFE, '0);
    tick();
    send_pkt(1, 1, 0, 0, 32'h0000_1234, '0);
    check("t2_no_start", (CN*DW)'(o_ch_start[1]), '0);
    tick();
    i_ch_done_tick = 4'b0010;
    tick();
    i_ch_done_tick = '0;
    check("t2_start1", (CN*DW)'(o_ch_start), (CN*DW)'(4'b0010));
    check("t2_slice1", (CN*DW)'(o_ch_output_pattern[DW +: DW]), (CN*DW)'(32'h0000_1234));
    check("t2_busy1", (CN*DW)'(o_ch_busy[1]), (CN*DW)'(1));
    tick();

    // Overwrite of pending slot: latest wins
    send_pkt(2, 1, 0, 0, 32'h0000_0077, '0);
    tick();
    send_pkt(2, 1, 0, 0, 32'h0000_0001, '0);
    check("t3_no_ovw", (CN*DW)'(o_overwrite_tick), '0);
    tick();
    send_pkt(2, 1, 0, 1, 32'h0000_0002, '0);
    check("t3_ovw", (CN*DW)'(o_overwrite_tick), (CN*DW)'(1));
    tick();
    i_ch_done_tick = 4'b0100;
    tick();
    i_ch_done_tick = '0;
    check("t3_start2", (CN*DW)'(o_ch_start), (CN*DW)'(4'b0100));
    check("t3_slice2", (CN*DW)'(o_ch_output_pattern[2*DW +: DW]), (CN*DW)'(32'h0000_0002));
    tick(); tick();

    // Stop together with done tick discards the pending command
    send_pkt(0, 1, 0, 0, 32'h0000_B0B0, '0);
    tick();
    send_pkt(0, 0, 1, 0, 32'h0000_0000, 4'b0001);
    check("t4_stop0", (CN*DW)'(o_ch_stop), (CN*DW)'(4'b0001));
    check("t4_busy0", (CN*DW)'(o_ch_busy[0]), '0);
    check("t4_nostart", (CN*DW)'(o_ch_start), '0);
    tick(); tick();
    check("t4_nostart_late", (CN*DW)'(o_ch_start), '0);

    // Broadcast and out-of-range select
    send_pkt(1, 0, 1, 0, '0, '0); tick();
    send_pkt(2, 0, 1, 0, '0, '0); tick();
    send_pkt(15, 1, 0, 0, 32'h0000_F00D, '0);
`ifdef BROADCAST_EN
    check("t5_bcast_start", (CN*DW)'(o_ch_start), (CN*DW)'(4'b1111));
`else
    check("t5_bcast_err", (CN*DW)'(o_err_tick), (CN*DW)'(1));
    check("t5_bcast_nostart", (CN*DW)'(o_ch_start), '0);
`endif
    tick();
    send_pkt(5, 1, 0, 0, 32'h0000_0005, '0);
    check("t5_sel5_err", (CN*DW)'(o_err_tick), (CN*DW)'(1));
    check("t5_sel5_nostart", (CN*DW)'(o_ch_start), '0);
    tick();

    // Reset while in dispatch aborts the packet
    i_pkt_valid = 1; i_sel_out = 4'd3; i_start = 1; i_stop = 0;
    i_output_pattern = 32'h3333_3333;
    tick();
    i_pkt_valid = 0; rst = 1;
    tick();
    rst = 0;
    check("t6_start", (CN*DW)'(o_ch_start), '0);
    check("t6_busy", (CN*DW)'(o_ch_busy), '0);
    check("t6_ready", (CN*DW)'(o_pkt_ready), (CN*DW)'(1));
    check("t6_pat", o_ch_output_pattern, '0);
    tick(); tick();
    check("t6_not_issued", (CN*DW)'(o_ch_start), '0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      i_pkt_valid = ($urandom_range(0, 1) == 1);
      i_sel_out = ($urandom_range(0, 5) == 0) ? SW'($urandom_range(0, 15)) : SW'($urandom_range(0, CN-1));
      i_start = ($urandom_range(0, 3) != 0);
      i_stop = ($urandom_range(0, 5) == 0);
      i_mode = 1'($urandom_range(0, 1));
      i_output_pattern = $urandom;
      i_freq_pattern = $urandom;
      for (int k = 0; k < CN; k++) i_ch_done_tick[k] = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0; i_pkt_valid = 0; i_ch_done_tick = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
